// File: rtl/lsu_if.sv
// Bundle, memory-bus and write-back signals of the load/store stage.
// master = the lsu itself, slave = upstream/memory/write-back environment.
interface lsu_if;
  logic        lsu_receive_valid;
  logic        lsu_send_ready;
  logic [31:0] alu_result_input;
  logic [31:0] rsb_input;
  logic        ren_input;
  logic        wen_input;
  logic [7:0]  wmask_input;
  logic [31:0] rmask_input;
  logic        memory_read_signed_input;
  logic        reg_write_en_input;
  logic [4:0]  rd_input;
  logic [31:0] pc_input;

  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_resp_valid;
  logic        mem_resp_ready;
  logic [31:0] mem_rdata;

  logic        lsu_send_valid;
  logic        lsu_receive_ready;
  logic [31:0] result;
  logic [4:0]  rd;
  logic        reg_write_en;
  logic [31:0] pc;

  modport master (
    input  lsu_receive_valid, alu_result_input, rsb_input, ren_input, wen_input,
           wmask_input, rmask_input, memory_read_signed_input, reg_write_en_input,
           rd_input, pc_input, mem_req_ready, mem_resp_valid, mem_rdata,
           lsu_receive_ready,
    output lsu_send_ready, mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wstrb,
           mem_resp_ready, lsu_send_valid, result, rd, reg_write_en, pc
  );

  modport slave (
    output lsu_receive_valid, alu_result_input, rsb_input, ren_input, wen_input,
           wmask_input, rmask_input, memory_read_signed_input, reg_write_en_input,
           rd_input, pc_input, mem_req_ready, mem_resp_valid, mem_rdata,
           lsu_receive_ready,
    input  lsu_send_ready, mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wstrb,
           mem_resp_ready, lsu_send_valid, result, rd, reg_write_en, pc
  );
endinterface

// File: rtl/lsu.sv
// Single-entry load/store stage: one bundle in flight, at most one bus transaction,
// load alignment/extension, result held until write-back takes it.
module lsu (
  input  logic        clk,
  input  logic        rst,
  lsu_if.master       bus,
  output logic [2:0]  lsu_state_o
);
  typedef enum logic [1:0] {IDLE, REQ, RESP, SEND} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, rsb_q, rmask_q, pc_q, result_q;
  logic [3:0]  wmask_q;
  logic        ren_q, wen_q, sgn_q, rwe_q;
  logic [4:0]  rd_q;

  logic        accept;
  logic        resp_take;
  logic [1:0]  off;
  logic [31:0] shifted, raw, load_val;
  logic        unused_wmask_hi;

  assign unused_wmask_hi = ^bus.wmask_input[7:4];

  assign accept    = (state_q == IDLE) && !rst && bus.lsu_receive_valid;
  assign resp_take = (state_q == RESP) && bus.mem_resp_valid;
  assign off       = addr_q[1:0];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = (bus.ren_input || bus.wen_input) ? REQ : SEND;
      REQ:  if (bus.mem_req_ready) state_d = RESP;
      RESP: if (bus.mem_resp_valid) state_d = SEND;
      SEND: if (bus.lsu_receive_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Lanes shifted out past byte 3 are simply dropped; misalignment is not trapped.
  always_comb begin
    shifted  = bus.mem_rdata >> {off, 3'b000};
    raw      = shifted & rmask_q;
    load_val = raw;
    if (sgn_q) begin
      if (rmask_q == 32'h0000_00FF)      load_val = {{24{raw[7]}}, raw[7:0]};
      else if (rmask_q == 32'h0000_FFFF) load_val = {{16{raw[15]}}, raw[15:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q   <= '0;
      rsb_q    <= '0;
      rmask_q  <= '0;
      pc_q     <= '0;
      result_q <= '0;
      wmask_q  <= '0;
      ren_q    <= 1'b0;
      wen_q    <= 1'b0;
      sgn_q    <= 1'b0;
      rwe_q    <= 1'b0;
      rd_q     <= '0;
    end else if (accept) begin
      addr_q   <= bus.alu_result_input;
      rsb_q    <= bus.rsb_input;
      rmask_q  <= bus.rmask_input;
      pc_q     <= bus.pc_input;
      result_q <= bus.alu_result_input;
      wmask_q  <= bus.wmask_input[3:0];
      ren_q    <= bus.ren_input;
      wen_q    <= bus.wen_input;
      sgn_q    <= bus.memory_read_signed_input;
      rwe_q    <= bus.reg_write_en_input;
      rd_q     <= bus.rd_input;
    end else if (resp_take && ren_q) begin
      // Store acks keep the address result captured at accept.
      result_q <= load_val;
    end
  end

  assign bus.lsu_send_ready = (state_q == IDLE) && !rst;
  assign bus.mem_req_valid  = (state_q == REQ);
  assign bus.mem_resp_ready = (state_q == RESP);
  assign bus.lsu_send_valid = (state_q == SEND);

  // A bundle with both ren and wen set is a load.
  assign bus.mem_addr  = {addr_q[31:2], 2'b00};
  assign bus.mem_wen   = wen_q && !ren_q;
  assign bus.mem_wdata = rsb_q << {off, 3'b000};
  assign bus.mem_wstrb = wmask_q << off;

  assign bus.result       = result_q;
  assign bus.rd           = rd_q;
  assign bus.reg_write_en = rwe_q;
  assign bus.pc           = pc_q;

  assign lsu_state_o = (state_q == IDLE) ? 3'b000 : {ren_q, rwe_q, 1'b1};
endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: stimulus pushes expected bus requests/results into queues,
// a negedge monitor pops and compares them at each handshake and checks stall stability.
module tb_lsu;
  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] state_o;

  always #5 clk = ~clk;

  lsu_if bus();

  lsu dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.master),
    .lsu_state_o (state_o)
  );

  typedef struct {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  typedef struct {
    logic [31:0] result;
    logic [4:0]  rd;
    logic        rwe;
    logic [31:0] pc;
  } res_t;

  req_t req_q[$];
  res_t res_q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor
  logic p_req, p_send;
  req_t p_r, m_r;
  res_t p_s, m_s;

  always @(negedge clk) begin
    if (rst) begin
      p_req  = 1'b0;
      p_send = 1'b0;
    end else begin
      if (p_req) begin
        chk("req_hold_valid", bus.mem_req_valid, 1);
        chk("req_hold_addr", bus.mem_addr, p_r.addr);
        chk("req_hold_wen", bus.mem_wen, p_r.wen);
        chk("req_hold_wdata", bus.mem_wdata, p_r.wdata);
        chk("req_hold_wstrb", bus.mem_wstrb, p_r.wstrb);
      end
      if (p_send) begin
        chk("send_hold_valid", bus.lsu_send_valid, 1);
        chk("send_hold_result", bus.result, p_s.result);
        chk("send_hold_rd", bus.rd, p_s.rd);
        chk("send_hold_pc", bus.pc, p_s.pc);
      end
      if (bus.mem_req_valid && bus.mem_req_ready) begin
        if (req_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_req: got addr 0x%08h, none required", bus.mem_addr);
        end else begin
          m_r = req_q.pop_front();
          chk("req_addr", bus.mem_addr, m_r.addr);
          chk("req_wen", bus.mem_wen, m_r.wen);
          if (m_r.wen) begin
            chk("req_wdata", bus.mem_wdata, m_r.wdata);
            chk("req_wstrb", bus.mem_wstrb, m_r.wstrb);
          end
        end
      end
      if (bus.lsu_send_valid && bus.lsu_receive_ready) begin
        if (res_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_send: got result 0x%08h, none required", bus.result);
        end else begin
          m_s = res_q.pop_front();
          chk("res_result", bus.result, m_s.result);
          chk("res_rd", bus.rd, m_s.rd);
          chk("res_rwe", bus.reg_write_en, m_s.rwe);
          chk("res_pc", bus.pc, m_s.pc);
        end
      end
      p_req  = bus.mem_req_valid && !bus.mem_req_ready;
      p_r    = '{bus.mem_addr, bus.mem_wen, bus.mem_wdata, bus.mem_wstrb};
      p_send = bus.lsu_send_valid && !bus.lsu_receive_ready;
      p_s    = '{bus.result, bus.rd, bus.reg_write_en, bus.pc};
    end
  end

  task automatic scramble_inputs();
    bus.alu_result_input         = 32'hDEAD_BEEF;
    bus.rsb_input                = 32'h5A5A_5A5A;
    bus.ren_input                = 1'b1;
    bus.wen_input                = 1'b1;
    bus.wmask_input              = 8'hFF;
    bus.rmask_input              = 32'h0;
    bus.memory_read_signed_input = 1'b1;
    bus.reg_write_en_input       = 1'b0;
    bus.rd_input                 = 5'h1F;
    bus.pc_input                 = 32'h0;
  endtask

  // Called and returns at posedge+1.
  task automatic run_op(input string tag, input logic [31:0] alu, input logic [31:0] rsb,
                        input logic [7:0] wmask, input logic [31:0] rmask,
                        input logic ren, input logic wen, input logic sgn, input logic rwe,
                        input logic [4:0] rd, input logic [31:0] pc, input logic [31:0] rdata,
                        input logic [31:0] exp_addr, input logic [31:0] exp_res,
                        input logic [31:0] exp_wdata, input logic [3:0] exp_wstrb,
                        input int req_stall, input int resp_stall, input int send_stall);
    logic mem;
    mem = ren | wen;
    if (mem) req_q.push_back('{exp_addr, wen & ~ren, exp_wdata, exp_wstrb});
    res_q.push_back('{exp_res, rd, rwe, pc});
    bus.alu_result_input         = alu;
    bus.rsb_input                = rsb;
    bus.wmask_input              = wmask;
    bus.rmask_input              = rmask;
    bus.ren_input                = ren;
    bus.wen_input                = wen;
    bus.memory_read_signed_input = sgn;
    bus.reg_write_en_input       = rwe;
    bus.rd_input                 = rd;
    bus.pc_input                 = pc;
    bus.lsu_receive_valid        = 1'b1;
    @(negedge clk);
    chk({tag, "_rdy_idle"}, bus.lsu_send_ready, 1);
    @(posedge clk); #1;
    bus.lsu_receive_valid = 1'b0;
    scramble_inputs();
    if (mem) begin
      for (int i = 0; i <= req_stall; i++) begin
        bus.mem_req_ready = (i == req_stall);
        @(negedge clk);
        chk({tag, "_req_valid"}, bus.mem_req_valid, 1);
        chk({tag, "_rdy_busy"}, bus.lsu_send_ready, 0);
        chk({tag, "_send_early"}, bus.lsu_send_valid, 0);
        @(posedge clk); #1;
      end
      bus.mem_req_ready = 1'b0;
      for (int i = 0; i <= resp_stall; i++) begin
        bus.mem_resp_valid = (i == resp_stall);
        bus.mem_rdata      = (i == resp_stall) ? rdata : 32'hA5A5_A5A5;
        @(negedge clk);
        chk({tag, "_resp_ready"}, bus.mem_resp_ready, 1);
        chk({tag, "_req_dropped"}, bus.mem_req_valid, 0);
        chk({tag, "_send_early"}, bus.lsu_send_valid, 0);
        @(posedge clk); #1;
      end
      bus.mem_resp_valid = 1'b0;
      bus.mem_rdata      = 32'h0BAD_0BAD;
    end
    for (int i = 0; i <= send_stall; i++) begin
      bus.lsu_receive_ready = (i == send_stall);
      @(negedge clk);
      chk({tag, "_send_valid"}, bus.lsu_send_valid, 1);
      chk({tag, "_state"}, {29'd0, state_o}, {29'd0, ren, rwe, 1'b1});
      chk({tag, "_rdy_send"}, bus.lsu_send_ready, 0);
      chk({tag, "_no_req"}, bus.mem_req_valid, 0);
      @(posedge clk); #1;
    end
    bus.lsu_receive_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_send_done"}, bus.lsu_send_valid, 0);
    chk({tag, "_state_idle"}, {29'd0, state_o}, 32'd0);
    chk({tag, "_rdy_again"}, bus.lsu_send_ready, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    rst                   = 1'b1;
    bus.lsu_receive_valid = 1'b0;
    bus.mem_req_ready     = 1'b0;
    bus.mem_resp_valid    = 1'b0;
    bus.mem_rdata         = 32'h0;
    bus.lsu_receive_ready = 1'b0;
    scramble_inputs();
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_send_ready", bus.lsu_send_ready, 0);
    chk("rst_req_valid", bus.mem_req_valid, 0);
    chk("rst_resp_ready", bus.mem_resp_ready, 0);
    chk("rst_send_valid", bus.lsu_send_valid, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_state", {29'd0, state_o}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", bus.lsu_send_ready, 1);
    @(posedge clk); #1;

    run_op("add", 32'h1234, 0, 8'h00, 0, 0, 0, 0, 1, 5'd5, 32'h100, 0,
           0, 32'h1234, 0, 4'h0, 0, 0, 0);
    run_op("lb", 32'h8000_0003, 0, 8'h00, 32'hFF, 1, 0, 1, 1, 5'd10, 32'h104, 32'h80FF_FFFF,
           32'h8000_0000, 32'hFFFF_FF80, 0, 4'h0, 0, 0, 0);
    run_op("lhu", 32'h8000_0002, 0, 8'h00, 32'hFFFF, 1, 0, 0, 1, 5'd11, 32'h108, 32'hBEEF_1234,
           32'h8000_0000, 32'h0000_BEEF, 0, 4'h0, 0, 0, 0);
    run_op("sb", 32'h8000_0001, 32'hAB, 8'h01, 0, 0, 1, 0, 0, 5'd0, 32'h10C, 0,
           32'h8000_0000, 32'h8000_0001, 32'h0000_AB00, 4'b0010, 0, 1, 0);
    run_op("bp_lw", 32'h1000, 0, 8'h00, 32'hFFFF_FFFF, 1, 0, 1, 1, 5'd12, 32'h110, 32'hCAFE_F00D,
           32'h1000, 32'hCAFE_F00D, 0, 4'h0, 3, 0, 2);
    run_op("lh", 32'h40, 0, 8'h00, 32'hFFFF, 1, 0, 1, 1, 5'd13, 32'h114, 32'h1234_8765,
           32'h40, 32'hFFFF_8765, 0, 4'h0, 0, 2, 1);
    run_op("sw_mis", 32'h3, 32'h1122_3344, 8'hFF, 0, 0, 1, 0, 0, 5'd0, 32'h118, 0,
           32'h0, 32'h3, 32'h4400_0000, 4'b1000, 1, 0, 0);
    run_op("ld_st", 32'h21, 32'h55, 8'h0F, 32'hFF, 1, 1, 0, 1, 5'd14, 32'h11C, 32'h1122_3344,
           32'h20, 32'h33, 0, 4'h0, 0, 0, 0);
    run_op("lbu", 32'h7C, 0, 8'h00, 32'hFF, 1, 0, 0, 1, 5'd15, 32'h120, 32'h0000_00F0,
           32'h7C, 32'h0000_00F0, 0, 4'h0, 0, 0, 0);

    // Abort a load with reset while it waits for its response.
    req_q.push_back('{32'h8000_0010, 1'b0, 32'h0, 4'h0});
    bus.alu_result_input         = 32'h8000_0010;
    bus.ren_input                = 1'b1;
    bus.wen_input                = 1'b0;
    bus.rmask_input              = 32'hFFFF_FFFF;
    bus.reg_write_en_input       = 1'b1;
    bus.rd_input                 = 5'd7;
    bus.pc_input                 = 32'h300;
    bus.lsu_receive_valid        = 1'b1;
    @(posedge clk); #1;
    bus.lsu_receive_valid = 1'b0;
    bus.mem_req_ready     = 1'b1;
    @(posedge clk); #1;
    bus.mem_req_ready = 1'b0;
    @(negedge clk);
    chk("abort_in_resp", bus.mem_resp_ready, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst                = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = 32'h1234_5678;
    @(negedge clk);
    chk("abort_send_valid", bus.lsu_send_valid, 0);
    chk("abort_resp_ready", bus.mem_resp_ready, 0);
    chk("abort_req_valid", bus.mem_req_valid, 0);
    chk("abort_result", bus.result, 0);
    chk("abort_rd", bus.rd, 0);
    chk("abort_pc", bus.pc, 0);
    chk("abort_rwe", bus.reg_write_en, 0);
    chk("abort_mem_addr", bus.mem_addr, 0);
    chk("abort_state", {29'd0, state_o}, 0);
    chk("abort_send_ready", bus.lsu_send_ready, 1);
    @(posedge clk); #1;
    bus.mem_resp_valid = 1'b0;
    @(negedge clk);
    chk("stale_resp_ignored", bus.lsu_send_valid, 0);
    chk("stale_state", {29'd0, state_o}, 0);
    @(posedge clk); #1;

    chk("req_queue_drained", req_q.size(), 0);
    chk("res_queue_drained", res_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/lsu.md
# lsu

Load/store stage sitting directly downstream of the execute stage and upstream of write-back. It accepts one instruction bundle per valid/ready handshake, performs at most one memory transaction on a simple request/response bus, aligns and extends load data, and presents the final register write-back value to the next stage. It holds one instruction at a time: no buffering beyond the captured bundle.

## Interface
Parameters:
- none; all widths fixed (32-bit address/data, RV32).

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- lsu_receive_valid  in  1  upstream bundle valid
- lsu_send_ready  out  1  stage can accept a bundle
- alu_result_input  in  32  effective address (mem ops) or ALU result
- rsb_input  in  32  store data (rs2)
- ren_input / wen_input  in  1 each  load / store
- wmask_input  in  8  store byte strobes; [3:0] used, [7:4] ignored
- rmask_input  in  32  load mask: 0x000000FF, 0x0000FFFF or 0xFFFFFFFF
- memory_read_signed_input  in  1  sign-extend load
- reg_write_en_input  in  1  instruction writes rd
- rd_input  in  5  destination register
- pc_input  in  32  instruction pc (passed through)
- mem_req_valid  out  1  request valid
- mem_req_ready  in  1  request accepted
- mem_addr  out  32  word-aligned address {addr[31:2],2'b00}
- mem_wen  out  1  1 = write, 0 = read
- mem_wdata  out  32  lane-shifted store data
- mem_wstrb  out  4  lane-shifted byte strobes
- mem_resp_valid  in  1  response valid (read data or write ack)
- mem_resp_ready  out  1  stage accepts response
- mem_rdata  in  32  read data word
- lsu_send_valid  out  1  result bundle valid to write-back
- lsu_receive_ready  in  1  write-back accepts bundle
- result  out  32  load value or alu_result
- rd / reg_write_en / pc  out  5 / 1 / 32  held copies
- lsu_state_o  out  3  {is_load, reg_write_en, busy} of held instruction

## Operation
- FSM states IDLE, REQ, RESP, SEND; reset to IDLE.
- IDLE: lsu_send_ready=1 (0 while rst high). On lsu_receive_valid: latch all inputs; go REQ if ren|wen, else SEND with result=alu_result.
- REQ: mem_req_valid=1, mem_addr/mem_wen/mem_wdata/mem_wstrb stable until mem_req_ready; then RESP.
- RESP: mem_resp_ready=1; on mem_resp_valid capture data, go SEND. Stores also wait for the ack; store result=alu_result.
- SEND: lsu_send_valid=1, outputs stable; on lsu_receive_ready go IDLE.
- ren and wen both set: treated as load; wen ignored.
- off = addr[1:0]. Store: mem_wdata = rsb << 8*off; mem_wstrb = wmask[3:0] << off, truncated to 4 bits.
- Load: raw = (mem_rdata >> 8*off) & rmask; if signed, extend from bit 7 (rmask 0xFF) or bit 15 (0xFFFF); 0xFFFFFFFF unchanged.
- Misaligned accesses not trapped; lanes beyond byte 3 dropped.
- lsu_state_o = 0 in IDLE, else {ren_held, reg_write_en_held, 1}.

## Timing
- Reset: state IDLE; all registered outputs (result, rd, reg_write_en, pc, lsu_send_valid, mem_req_valid, mem_resp_ready, mem_* payload, lsu_state_o) = 0.
- Non-memory op: accepted cycle T, lsu_send_valid at T+1.
- Memory op, zero-wait bus: accept T, mem_req_valid T+1, RESP T+2, lsu_send_valid T+3. Each bus stall cycle adds one.
- New bundle accepted earliest the cycle after SEND handshake (no same-cycle accept in SEND).
- Valid must not drop without its ready; payloads stable while valid high.
- rst mid-transaction: aborts immediately to IDLE next cycle; outstanding bus response ignored.

## Test plan
- ADD passthrough: alu_result=0x1234, rd=5, reg_write_en=1 -> result=0x1234, rd=5 on lsu_send_valid one cycle after accept; no mem_req_valid.
- LB signed: addr=0x80000003, rmask=0xFF, signed=1, mem_rdata=0x80FFFFFF -> mem_addr=0x80000000, result=0xFFFFFF80.
- LHU: addr=0x80000002, rmask=0xFFFF, signed=0, mem_rdata=0xBEEF1234 -> result=0x0000BEEF.
- SB: addr=0x80000001, rsb=0xAB, wmask=0x01 -> mem_wen=1, mem_wdata=0x0000AB00, mem_wstrb=0b0010; send after ack.
- Backpressure: mem_req_ready low 3 cycles, lsu_receive_ready low 2 cycles -> request/result held stable, lsu_send_ready=0 throughout, single completion.
- Reset in RESP: rst pulsed while awaiting mem_resp_valid -> next cycle IDLE, all outputs 0, lsu_send_ready=1 after rst drops.
